// File: rtl/bomb_countdown.sv
// Bomb countdown: mm:ss BCD timer driven by a one-second tick, with
// penalties, defuse freeze, saturation at 00:00, expiry level and boom pulse.
module bomb_countdown #(
    parameter int START_MIN   = 5,
    parameter int START_SEC   = 0,
    parameter int PENALTY_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic       uno_second,
    input  logic       penalty,
    input  logic       defused,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       boom
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_DEFUSED = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam logic [6:0] START_MIN_B = 7'(START_MIN);
    localparam logic [6:0] START_SEC_B = 7'(START_SEC);
    localparam logic [6:0] PENALTY_B   = 7'(PENALTY_SEC);

    // Binary 0..99 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [6:0] min_bin_s;
    logic [6:0] sec_bin_s;
    logic [6:0] tick_amt_s;
    logic [6:0] pen_amt_s;
    logic [6:0] dec_s;
    logic [6:0] new_min_s;
    logic [6:0] new_sec_s;
    logic       cur_zero_s;
    logic       new_zero_s;
    logic       upd_s;
    logic       reload_s;
    logic       boom_next_s;

    // Saturating subtraction of this cycle's decrement, borrowing one minute
    // when seconds underflow (decrement never exceeds 60, so one borrow suffices).
    always_comb begin
        min_bin_s  = 7'(min_tens) * 7'd10 + 7'(min_ones);
        sec_bin_s  = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
        tick_amt_s = (uno_second && (state_r == ST_RUNNING)) ? 7'd1 : 7'd0;
        pen_amt_s  = (penalty && ((state_r == ST_RUNNING) || (state_r == ST_PAUSED)))
                     ? PENALTY_B : 7'd0;
        dec_s      = tick_amt_s + pen_amt_s;
        new_min_s  = min_bin_s;
        new_sec_s  = sec_bin_s;
        if (sec_bin_s >= dec_s) begin
            new_sec_s = sec_bin_s - dec_s;
            new_min_s = min_bin_s;
        end else if (min_bin_s == 7'd0) begin
            new_sec_s = 7'd0;
            new_min_s = 7'd0;
        end else begin
            new_sec_s = sec_bin_s + 7'd60 - dec_s;
            new_min_s = min_bin_s - 7'd1;
        end
        cur_zero_s = (min_bin_s == 7'd0) && (sec_bin_s == 7'd0);
        new_zero_s = (new_min_s == 7'd0) && (new_sec_s == 7'd0);
    end

    // Next-state logic: load beats defuse, defuse beats any time update.
    always_comb begin
        state_next_s = state_r;
        upd_s        = 1'b0;
        reload_s     = 1'b0;
        boom_next_s  = 1'b0;
        if (load) begin
            reload_s     = 1'b1;
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable && cur_zero_s) begin
                        state_next_s = ST_EXPIRED;
                        boom_next_s  = 1'b1;
                    end else if (enable) begin
                        state_next_s = ST_RUNNING;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (defused) begin
                        state_next_s = ST_DEFUSED;
                    end else begin
                        upd_s = 1'b1;
                        if (!cur_zero_s && new_zero_s) begin
                            state_next_s = ST_EXPIRED;
                            boom_next_s  = 1'b1;
                        end else if (!enable) begin
                            state_next_s = ST_PAUSED;
                        end else begin
                            state_next_s = ST_RUNNING;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (defused) begin
                        state_next_s = ST_DEFUSED;
                    end else begin
                        upd_s = 1'b1;
                        if (!cur_zero_s && new_zero_s) begin
                            state_next_s = ST_EXPIRED;
                            boom_next_s  = 1'b1;
                        end else if (enable) begin
                            state_next_s = ST_RUNNING;
                        end else begin
                            state_next_s = ST_PAUSED;
                        end
                    end
                end
                ST_DEFUSED: state_next_s = ST_DEFUSED;
                ST_EXPIRED: state_next_s = ST_EXPIRED;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, digit and flag registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r              <= ST_IDLE;
            {min_tens, min_ones} <= to_bcd(START_MIN_B);
            {sec_tens, sec_ones} <= to_bcd(START_SEC_B);
            running              <= 1'b0;
            expired              <= 1'b0;
            boom                 <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (reload_s) begin
                {min_tens, min_ones} <= to_bcd(START_MIN_B);
                {sec_tens, sec_ones} <= to_bcd(START_SEC_B);
            end else if (upd_s) begin
                {min_tens, min_ones} <= to_bcd(new_min_s);
                {sec_tens, sec_ones} <= to_bcd(new_sec_s);
            end else begin
                {min_tens, min_ones} <= {min_tens, min_ones};
                {sec_tens, sec_ones} <= {sec_tens, sec_ones};
            end
            running <= (state_next_s == ST_RUNNING);
            expired <= (state_next_s == ST_EXPIRED);
            boom    <= boom_next_s;
        end
    end

endmodule

// File: tb/tb_bomb_countdown.sv
// Self-checking bench for bomb_countdown: reset, vector table, directed
// corner sequences and a randomized run against a total-seconds model.
module tb_bomb_countdown;

    logic       clk = 1'b0;
    logic       rst, load, enable, uno_second, penalty, defused;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, boom;
    logic [3:0] z_min_tens, z_min_ones, z_sec_tens, z_sec_ones;
    logic       z_running, z_expired, z_boom;

    int checks   = 0;
    int failures = 0;

    localparam int START_T = 300;
    localparam int PEN     = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DEF = 3, M_EXP = 4;

    int   m_t;
    int   m_mode;
    logic m_boom;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    bomb_countdown #(.START_MIN(5), .START_SEC(0), .PENALTY_SEC(10)) dut (
        .clk(clk), .rst(rst), .load(load), .enable(enable),
        .uno_second(uno_second), .penalty(penalty), .defused(defused),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .expired(expired), .boom(boom)
    );

    bomb_countdown #(.START_MIN(0), .START_SEC(0), .PENALTY_SEC(10)) dut_zero (
        .clk(clk), .rst(rst), .load(load), .enable(enable),
        .uno_second(uno_second), .penalty(penalty), .defused(defused),
        .min_tens(z_min_tens), .min_ones(z_min_ones),
        .sec_tens(z_sec_tens), .sec_ones(z_sec_ones),
        .running(z_running), .expired(z_expired), .boom(z_boom)
    );

    typedef struct {
        logic       l, e, t, p, d;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [18:0] mk(input int mt, input int mo, input int st,
                                       input int so, input logic r, input logic x,
                                       input logic b);
        return {4'(mt), 4'(mo), 4'(st), 4'(so), r, x, b};
    endfunction

    function automatic logic [18:0] dut_out();
        return {min_tens, min_ones, sec_tens, sec_ones, running, expired, boom};
    endfunction

    function automatic logic [18:0] zero_out();
        return {z_min_tens, z_min_ones, z_sec_tens, z_sec_ones, z_running, z_expired, z_boom};
    endfunction

    function automatic logic [18:0] model_out();
        int m, s;
        m = m_t / 60;
        s = m_t % 60;
        return mk(m / 10, m % 10, s / 10, s % 10, m_mode == M_RUN, m_mode == M_EXP, m_boom);
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h%h:%h%h run=%b exp=%b boom=%b, expected %h%h:%h%h run=%b exp=%b boom=%b",
                     name, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                     exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference: total seconds with saturating subtraction and a mode number.
    task automatic model_update(input logic l, input logic e, input logic t,
                                input logic p, input logic d);
        int old_t, dec;
        m_boom = 1'b0;
        if (l) begin
            m_t    = START_T;
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (e && m_t == 0) begin
                m_mode = M_EXP;
                m_boom = 1'b1;
            end else if (e) begin
                m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
            if (d) begin
                m_mode = M_DEF;
            end else begin
                dec   = ((t && m_mode == M_RUN) ? 1 : 0) + (p ? PEN : 0);
                old_t = m_t;
                m_t   = (m_t > dec) ? m_t - dec : 0;
                if (old_t > 0 && m_t == 0) begin
                    m_mode = M_EXP;
                    m_boom = 1'b1;
                end else if (!e) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_mode = M_RUN;
                end
            end
        end
    endtask

    task automatic step(input logic l, input logic e, input logic t,
                        input logic p, input logic d);
        load = l; enable = e; uno_second = t; penalty = p; defused = d;
        model_update(l, e, t, p, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; enable = 1'b0; uno_second = 1'b0;
        penalty = 1'b0; defused = 1'b0;
        m_t = START_T; m_mode = M_IDLE; m_boom = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic l, e, t, p, d;
        // load, enable, tick, penalty, defused, expected outputs
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b1, 1'b0, 1'b0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 4, 5, 9, 1'b1, 1'b0, 1'b0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mk(0, 4, 4, 9, 1'b1, 1'b0, 1'b0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, mk(0, 4, 3, 8, 1'b1, 1'b0, 1'b0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 4, 3, 7, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 4, 3, 7, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 4, 2, 7, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 4, 2, 7, 1'b1, 1'b0, 1'b0)};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b1, 1'b0, 1'b0)};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0)};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 5, 0, 0, 1'b1, 1'b0, 1'b0)};

        // Reset state
        do_reset();
        check("reset", dut_out(), mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0));
        check("reset_zero_start", zero_out(), mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0));

        // Vector table from reset
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].l, tbl[i].e, tbl[i].t, tbl[i].p, tbl[i].d);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // 00:00 start: enable in IDLE expires at once with a single boom
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_start_boom", zero_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        check("run_after_enable", dut_out(), mk(0, 5, 0, 0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_start_boom_once", zero_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));

        // 65 ticks, then pause ignores ticks
        for (int i = 0; i < 65; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("65_ticks", dut_out(), mk(0, 3, 5, 5, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("paused_ticks", dut_out(), mk(0, 3, 5, 5, 1'b0, 1'b0, 1'b0));

        // 01:05 with tick and penalty together
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 170; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at_0105", dut_out(), mk(0, 1, 0, 5, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tick_plus_pen", dut_out(), mk(0, 0, 5, 4, 1'b1, 1'b0, 1'b0));

        // Final tick expires
        for (int i = 0; i < 53; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at_0001", dut_out(), mk(0, 0, 0, 1, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("tick_expire", dut_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("expired_hold", dut_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("expired_hold2", dut_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));

        // Penalty saturates at 00:08
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_after_expire", dut_out(), mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 292; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at_0008", dut_out(), mk(0, 0, 0, 8, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pen_saturate", dut_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pen_boom_once", dut_out(), mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));

        // Defuse at 02:30 with a concurrent tick, then reload
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at_0230", dut_out(), mk(0, 2, 3, 0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("defuse_freeze", dut_out(), mk(0, 2, 3, 0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("defused_ignore", dut_out(), mk(0, 2, 3, 0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("defused_load", dut_out(), mk(0, 5, 0, 0, 1'b0, 1'b0, 1'b0));

        // Defuse beats the tick that would reach 00:00
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 299; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at_0001_b", dut_out(), mk(0, 0, 0, 1, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("defuse_wins", dut_out(), mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("defuse_wins_hold", dut_out(), mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0));

        // Randomized run against the reference model
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            l = ($urandom_range(63) == 0);
            e = ($urandom_range(7) != 0);
            t = 1'($urandom_range(1));
            p = ($urandom_range(15) == 0);
            d = ($urandom_range(127) == 0);
            step(l, e, t, p, d);
            check($sformatf("random%0d", i), dut_out(), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
